dice_display: RTL and testbench
===============================

# dice_display

Output stage that consumes the 3-bit dice value produced by the dice controller and drives a seven-pip LED die face. It debounces a raw roll button, shows the live shuffling value while rolling, and freezes the face on a captured result. It keeps a saturating roll count and latches a sticky error when an invalid value (0 or 7) arrives.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive cycles the synchronised button must disagree with the debounced state before that state flips; legal range is 1–255.
- `SPIN_CYCLES`, default 64: number of cycles the face keeps shuffling after button release; legal range is 1–255.
- `BLINK_DIV`, default 8: half-period of the error blink, in cycles; legal range is 1–255.
- `Clock` in 1: single clock; all state changes on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `Button` in 1: raw, asynchronous roll button; high means pressed.
- `DiceValue` in 3: die value from the upstream controller. Legal values are 1–6.
- `Pips` out 7: LED pattern. Bit 0 is top-left, 1 mid-left, 2 bottom-left, 3 centre, 4 top-right, 5 mid-right, 6 bottom-right.
- `Rolling` out 1: high in the ROLL and SPIN states.
- `Error` out 1: sticky invalid-input flag.
- `RollCount` out 8: number of completed rolls, saturating at 255.
- `History` out 12: last four results. Bits [2:0] are the newest; see Configuration.

## Operation
- Pip encoding, decoded from a value:
  - 1 = 0x08, 2 = 0x41, 3 = 0x49
  - 4 = 0x55, 5 = 0x5D, 6 = 0x77
- Button path:
  - Two-flop synchroniser feeds the debouncer.
  - A counter increments while the synchronised level differs from the debounced level and clears when they agree.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
- State machine, all outputs registered:
  - **IDLE:** `Pips` shows the held value and `Rolling` = 0. On a debounced rising edge, go to ROLL.
  - **ROLL:** `Pips` shows the live `DiceValue`, sampled every cycle, and `Rolling` = 1. On a debounced falling edge, load the spin counter with `SPIN_CYCLES` and go to SPIN.
  - **SPIN:** `Pips` shows the live value and `Rolling` = 1. The counter decrements each cycle. In the cycle the counter is 1 (the capture cycle):
    - the held value becomes `DiceValue`;
    - `RollCount` increments unless it is already 255;
    - the state goes to IDLE.
    - Button activity in SPIN is ignored, and the debouncer keeps tracking.
  - **ERROR:** entered from any state the cycle after `DiceValue` is 0 or 7.
    - `Error` = 1 and `Rolling` = 0.
    - `Pips` alternates 0x7F and 0x00 every `BLINK_DIV` cycles, starting with 0x7F on the first ERROR cycle.
    - `RollCount` and `History` are frozen.
    - Only `Reset` exits this state.
- Boundary rules:
  - Invalid value in the capture cycle: ERROR wins. The held value, `RollCount` and `History` are unchanged.
  - Press and release both debounced within ROLL: the minimum ROLL residency is one cycle.
  - `RollCount` stays at 255 once reached.
  - Reset asserted in any state returns every register to its reset value at the next edge, including the synchroniser, the debouncer and both counters.

## Timing
- Reset values:
  - `Pips` = 0x08 (held value = 1)
  - `Rolling` = 0, `Error` = 0, `RollCount` = 0
  - `History` = 0x249 with History enabled, otherwise 0
- Button latency:
  - The debounced level flips `2 + DEBOUNCE_CYCLES` cycles after the raw level changes and holds.
  - The FSM changes state one cycle later.
  - `Rolling` changes together with the state.
- Live display: `Pips` reflects `DiceValue` with one cycle of latency.
- Spin: `SPIN_CYCLES` cycles are spent in SPIN. `Pips` shows the captured value and `RollCount` shows the new count one cycle after the capture edge.
- Error: `Error` and the first 0x7F pattern appear one cycle after the invalid `DiceValue` is sampled.

## Configuration
- Macro: `DICE_DISPLAY_HISTORY_EN`.
- Defined: `History` is a 4-deep, 3-bit shift register. On every capture, the captured value shifts in at [2:0] and the older entries move up. Reset value is 0x249 (four 1s).
- Undefined: `History` is tied to 0 and no history flops exist. All other behaviour is identical.

## Test plan
- **Reset:** hold `Reset` 3 cycles with `DiceValue` = 1 → `Pips` = 0x08, `Rolling` = 0, `Error` = 0, `RollCount` = 0, `History` = 0x249 (macro on).
- **Debounce:** bounce `Button` high for 10 cycles, low for 5, then high steadily (`DEBOUNCE_CYCLES` = 16) → `Rolling` rises exactly 19 cycles after the final rising edge; no earlier transition.
- **Full roll:**
  - Drive `DiceValue` with 3,5,2,… while ROLL is held, then release.
  - With `DiceValue` = 4 in the capture cycle, `Rolling` falls after `SPIN_CYCLES` = 64 cycles in SPIN.
  - Then `Pips` = 0x55, `RollCount` = 1, `History[2:0]` = 4.
- **Error in capture cycle:** `DiceValue` = 7 in the capture cycle → next cycle `Error` = 1 and `Pips` = 0x7F for 8 cycles, then 0x00 for 8; `RollCount` unchanged; pressing the button has no effect.
- **Saturation:** complete 256 rolls → `RollCount` = 255 and stays at 255.
- **Reset mid-SPIN:** assert `Reset` in SPIN → next cycle all outputs are at their reset values; a new press is required to roll again.

Source files
------------

// File: rtl/dice_display.sv
// -----------------------------------------------------------------------------
// dice_display
//
// Output stage for the dice controller. Synchronises and debounces a raw roll
// button, shows the live shuffling value while the button is held and for a
// fixed spin time after release, then freezes the face on the captured value.
// Keeps a saturating roll count and enters a sticky, blinking error state when
// an invalid die value (0 or 7) arrives. Only Reset leaves the error state.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles of disagreement before the debounced level flips (1-255)
//   SPIN_CYCLES      cycles spent shuffling after release (1-255)
//   BLINK_DIV        half-period of the error blink in cycles (1-255)
//
// Ports:
//   Clock      in   single clock, rising edge
//   Reset      in   synchronous, active-high reset
//   Button     in   raw asynchronous roll button, high = pressed
//   DiceValue  in   [2:0] die value from the controller, legal 1-6
//   Pips       out  [6:0] LED face (0 TL, 1 ML, 2 BL, 3 C, 4 TR, 5 MR, 6 BR)
//   Rolling    out  high while rolling or spinning
//   Error      out  sticky invalid-input flag
//   RollCount  out  [7:0] completed rolls, saturating at 255
//   History    out  [11:0] last four results, newest in [2:0]
//
// Configuration macro:
//   DICE_DISPLAY_HISTORY_EN  when defined, History is a 4-deep shift register
//                            of captured values; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module dice_display #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SPIN_CYCLES     = 64,
  parameter int BLINK_DIV       = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Button,
  input  logic [2:0]  DiceValue,
  output logic [6:0]  Pips,
  output logic        Rolling,
  output logic        Error,
  output logic [7:0]  RollCount,
  output logic [11:0] History
);

  typedef enum logic [1:0] {ST_IDLE, ST_ROLL, ST_SPIN, ST_ERROR} state_t;

  function automatic logic [6:0] pip_decode(input logic [2:0] value);
    case (value)
      3'd1:    pip_decode = 7'h08;
      3'd2:    pip_decode = 7'h41;
      3'd3:    pip_decode = 7'h49;
      3'd4:    pip_decode = 7'h55;
      3'd5:    pip_decode = 7'h5D;
      3'd6:    pip_decode = 7'h77;
      default: pip_decode = 7'h00;
    endcase
  endfunction

  logic [1:0] sync_q;
  logic       db_level;
  logic       db_prev;
  logic [7:0] db_cnt;
  logic       db_rise;
  logic       db_fall;

  state_t     state_q, state_d;
  logic [7:0] spin_cnt, spin_d;
  logic [7:0] blink_cnt, blink_cnt_d;
  logic       blink_on, blink_on_d;
  logic [2:0] held;
  logic       capture;
  logic       value_bad;
  logic [6:0] pips_d;
  logic       rolling_d;
  logic       error_d;

  // ---------------------------------------------------------------------------
  // Button path: two-flop synchroniser, then a disagreement counter. The
  // debounced level only flips after DEBOUNCE_CYCLES consecutive disagreeing
  // samples; any agreeing sample restarts the count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    // NOTE: sequential state is written with <= so every flop samples the
    // values from before the edge, independent of statement order.
    if (Reset) begin
      sync_q   <= 2'b00;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync_q  <= {sync_q[0], Button};
      db_prev <= db_level;
      if (sync_q[1] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
    end
  end

  // Edges are seen one cycle after the debounced level flips.
  assign db_rise = db_level & ~db_prev;
  assign db_fall = ~db_level & db_prev;

  assign value_bad = (DiceValue == 3'd0) || (DiceValue == 3'd7);

  // ---------------------------------------------------------------------------
  // Next state and next (registered) outputs. Outputs are derived from the
  // next state so Rolling/Error/Pips change on the same edge as the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is
    // inferred on paths that do not assign it.
    state_d     = state_q;
    spin_d      = spin_cnt;
    blink_cnt_d = blink_cnt;
    blink_on_d  = blink_on;
    capture     = 1'b0;

    if (state_q != ST_ERROR && value_bad) begin
      // An invalid value wins over everything, including a capture.
      state_d     = ST_ERROR;
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (db_rise) state_d = ST_ROLL;
        ST_ROLL: begin
          if (db_fall) begin
            state_d = ST_SPIN;
            spin_d  = 8'(SPIN_CYCLES);
          end
        end
        ST_SPIN: begin
          if (spin_cnt == 8'd1) begin
            state_d = ST_IDLE;
            capture = 1'b1;
          end else begin
            spin_d = spin_cnt - 8'd1;
          end
        end
        ST_ERROR: begin
          if (blink_cnt == 8'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on;
          end else begin
            blink_cnt_d = blink_cnt + 8'd1;
          end
        end
      endcase
    end

    rolling_d = (state_d == ST_ROLL) || (state_d == ST_SPIN);
    error_d   = (state_d == ST_ERROR);
    case (state_d)
      ST_IDLE:  pips_d = pip_decode(capture ? DiceValue : held);
      ST_ERROR: pips_d = blink_on_d ? 7'h7F : 7'h00;
      default:  pips_d = pip_decode(DiceValue);
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      spin_cnt  <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b0;
      held      <= 3'd1;
      Pips      <= 7'h08;
      Rolling   <= 1'b0;
      Error     <= 1'b0;
      RollCount <= '0;
    end else begin
      state_q   <= state_d;
      spin_cnt  <= spin_d;
      blink_cnt <= blink_cnt_d;
      blink_on  <= blink_on_d;
      Pips      <= pips_d;
      Rolling   <= rolling_d;
      Error     <= error_d;
      if (capture) begin
        held <= DiceValue;
        if (RollCount != 8'hFF) RollCount <= RollCount + 8'd1;
      end
    end
  end

`ifdef DICE_DISPLAY_HISTORY_EN
  logic [11:0] hist_q;

  always_ff @(posedge Clock) begin
    if (Reset)        hist_q <= 12'h249;
    else if (capture) hist_q <= {hist_q[8:0], DiceValue};
  end

  assign History = hist_q;
`else
  assign History = '0;
`endif

endmodule

// File: tb/tb_dice_display.sv
// -----------------------------------------------------------------------------
// tb_dice_display
//
// Self-checking bench for dice_display. Every cycle the outputs are compared
// with a behavioural model that tracks button history as a sample window and
// the display mode as plain counters. Directed sequences cover reset,
// debounce latency, a full roll, an error in the capture cycle, count
// saturation and reset during spin; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_dice_display;

  localparam int DEB   = 16;
  localparam int SPIN  = 64;
  localparam int BLINK = 8;

`ifdef DICE_DISPLAY_HISTORY_EN
  localparam bit HIST_EN = 1'b1;
`else
  localparam bit HIST_EN = 1'b0;
`endif
  localparam logic [11:0] HIST_RST = HIST_EN ? 12'h249 : 12'h000;

  logic        Clock;
  logic        Reset;
  logic        Button;
  logic [2:0]  DiceValue;
  logic [6:0]  Pips;
  logic        Rolling;
  logic        Error;
  logic [7:0]  RollCount;
  logic [11:0] History;

  dice_display #(
    .DEBOUNCE_CYCLES(DEB),
    .SPIN_CYCLES    (SPIN),
    .BLINK_DIV      (BLINK)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Button   (Button),
    .DiceValue(DiceValue),
    .Pips     (Pips),
    .Rolling  (Rolling),
    .Error    (Error),
    .RollCount(RollCount),
    .History  (History)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_ROLL, M_SPIN, M_ERR} mode_t;

  logic [6:0] pip_tbl [0:7] = '{7'h00, 7'h08, 7'h41, 7'h49, 7'h55, 7'h5D, 7'h77, 7'h00};

  bit    dly[$];        // raw button samples still in flight to the debouncer
  bit    win[$];        // recent synchronised samples since the last flip
  bit    m_lvl;
  bit    pend_rise, pend_fall;
  mode_t mode;
  int    spin_left, blink_t, m_held, m_cnt;
  int    m_hist;
  logic [6:0] e_pips;
  bit    e_roll, e_err;

  task automatic model_step(input bit rst, input bit btn, input logic [2:0] dv);
    bit s, rise, fall, all_differ;
    if (rst) begin
      dly = '{1'b0, 1'b0};
      win.delete();
      m_lvl = 0; pend_rise = 0; pend_fall = 0;
      mode = M_IDLE; spin_left = 0; blink_t = 0;
      m_held = 1; m_cnt = 0; m_hist = int'(HIST_RST);
    end else begin
      rise = pend_rise;
      fall = pend_fall;
      s = dly.pop_front();
      dly.push_back(btn);
      win.push_back(s);
      if (win.size() > DEB) void'(win.pop_front());
      pend_rise = 0; pend_fall = 0;
      all_differ = (win.size() == DEB);
      foreach (win[i]) if (win[i] == m_lvl) all_differ = 0;
      if (all_differ) begin
        m_lvl = !m_lvl;
        pend_rise = m_lvl;
        pend_fall = !m_lvl;
        win.delete();
      end

      if (mode == M_ERR) blink_t++;
      else if (dv == 3'd0 || dv == 3'd7) begin
        mode = M_ERR;
        blink_t = 0;
      end else begin
        case (mode)
          M_IDLE: if (rise) mode = M_ROLL;
          M_ROLL: if (fall) begin mode = M_SPIN; spin_left = SPIN; end
          M_SPIN: begin
            if (spin_left == 1) begin
              mode   = M_IDLE;
              m_held = int'(dv);
              m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
              if (HIST_EN) m_hist = ((m_hist * 8) + int'(dv)) % 4096;
            end else spin_left--;
          end
          default: ;
        endcase
      end
    end
    e_roll = (mode == M_ROLL) || (mode == M_SPIN);
    e_err  = (mode == M_ERR);
    case (mode)
      M_ERR:   e_pips = (((blink_t / BLINK) % 2) == 0) ? 7'h7F : 7'h00;
      M_IDLE:  e_pips = pip_tbl[m_held];
      default: e_pips = pip_tbl[dv];
    endcase
  endtask

  // Drive one cycle, step the model, compare after the edge.
  task automatic tick(input bit rst, input bit btn, input logic [2:0] dv);
    Reset = rst; Button = btn; DiceValue = dv;
    model_step(rst, btn, dv);
    @(posedge Clock);
    #1;
    check("model_pips",    Pips,      e_pips);
    check("model_rolling", Rolling,   e_roll);
    check("model_error",   Error,     e_err);
    check("model_count",   RollCount, m_cnt);
    check("model_history", History,   m_hist);
  endtask

  function automatic logic [2:0] rand_dv();
    return 3'($urandom_range(1, 6));
  endfunction

  // Press long enough to enter ROLL plus two cycles, then release and let the
  // spin finish with cap presented in the capture cycle.
  task automatic do_roll(input logic [2:0] cap);
    for (int i = 0; i < DEB + 5; i++) tick(0, 1, rand_dv());
    for (int i = 1; i <= DEB + SPIN + 3; i++)
      tick(0, 0, (i == DEB + SPIN + 3) ? cap : rand_dv());
  endtask

  typedef struct {
    logic [2:0] dv;
    logic [6:0] pips;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int rise_at, roll_hi, left;
    bit saw_early, b, r;
    logic [2:0] d, pat [3];

    vecs[0] = '{3'd3, 7'h49};
    vecs[1] = '{3'd5, 7'h5D};
    vecs[2] = '{3'd2, 7'h41};
    vecs[3] = '{3'd1, 7'h08};
    vecs[4] = '{3'd6, 7'h77};
    vecs[5] = '{3'd4, 7'h55};
    pat[0] = 3'd3; pat[1] = 3'd5; pat[2] = 3'd2;

    // Reset
    for (int i = 0; i < 3; i++) tick(1, 0, 3'd1);
    check("rst_pips",    Pips,      7'h08);
    check("rst_rolling", Rolling,   1'b0);
    check("rst_error",   Error,     1'b0);
    check("rst_count",   RollCount, 8'd0);
    check("rst_history", History,   HIST_RST);

    // Debounce: bounce high 10, low 5, then steady high
    saw_early = 0;
    for (int i = 0; i < 10; i++) begin tick(0, 1, 3'd1); saw_early |= Rolling; end
    for (int i = 0; i < 5; i++)  begin tick(0, 0, 3'd1); saw_early |= Rolling; end
    rise_at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick(0, 1, 3'd1);
      if (Rolling && rise_at < 0) rise_at = i;
    end
    check("bounce_no_early", saw_early, 1'b0);
    check("rise_latency",    rise_at,   DEB + 3);

    // Live display in ROLL, table-driven
    foreach (vecs[i]) begin
      tick(0, 1, vecs[i].dv);
      check("live_pips", Pips, vecs[i].pips);
    end
    check("roll_rolling", Rolling, 1'b1);

    // Release and spin, 4 in the capture cycle
    roll_hi = 0;
    for (int i = 1; i <= DEB + SPIN + 3; i++) begin
      tick(0, 0, (i == DEB + SPIN + 3) ? 3'd4 : pat[i % 3]);
      if (i < DEB + SPIN + 3) roll_hi += int'(Rolling);
    end
    check("spin_rolling_cycles", roll_hi,   DEB + SPIN + 2);
    check("cap_rolling",         Rolling,   1'b0);
    check("cap_pips",            Pips,      7'h55);
    check("cap_count",           RollCount, 8'd1);
    check("cap_history",         History,   HIST_EN ? 12'h24C : 12'h000);

    // Invalid value in capture cycle
    do_roll(3'd7);
    check("err_flag",  Error, 1'b1);
    check("err_pips0", Pips,  7'h7F);
    for (int i = 1; i < 2 * BLINK; i++) begin
      tick(0, 1, rand_dv());
      check("err_blink", Pips, (i < BLINK) ? 7'h7F : 7'h00);
    end
    for (int i = 0; i < 40; i++) tick(0, 1, rand_dv());
    for (int i = 0; i < 30; i++) tick(0, 0, rand_dv());
    check("err_sticky",  Error,     1'b1);
    check("err_rolling", Rolling,   1'b0);
    check("err_count",   RollCount, 8'd1);
    check("err_history", History,   HIST_EN ? 12'h24C : 12'h000);

    // Reset mid-SPIN
    tick(1, 0, 3'd1);
    for (int i = 0; i < DEB + 5; i++) tick(0, 1, rand_dv());
    for (int i = 0; i < DEB + 13; i++) tick(0, 0, rand_dv());
    check("spin_before_rst", Rolling, 1'b1);
    tick(1, 0, rand_dv());
    check("mid_rst_pips",    Pips,      7'h08);
    check("mid_rst_rolling", Rolling,   1'b0);
    check("mid_rst_error",   Error,     1'b0);
    check("mid_rst_count",   RollCount, 8'd0);
    check("mid_rst_history", History,   HIST_RST);
    for (int i = 0; i < 60; i++) tick(0, 0, rand_dv());
    check("no_roll_without_press", Rolling, 1'b0);
    do_roll(3'd5);
    check("reroll_pips",  Pips,      7'h5D);
    check("reroll_count", RollCount, 8'd1);

    // Saturation
    tick(1, 0, 3'd1);
    for (int i = 0; i < 255; i++) do_roll(rand_dv());
    check("sat_255", RollCount, 8'd255);
    do_roll(3'd2);
    do_roll(3'd6);
    check("sat_hold",      RollCount, 8'd255);
    check("sat_last_pips", Pips,      7'h77);

    // Randomized phase against the model
    tick(1, 0, 3'd1);
    left = 0;
    b = 0;
    for (int c = 0; c < 4000; c++) begin
      if (left == 0) begin
        b = 1'($urandom_range(0, 1));
        left = $urandom_range(1, 40);
      end
      left--;
      r = ($urandom_range(0, 299) == 0);
      d = ($urandom_range(0, 1499) == 0) ? ($urandom_range(0, 1) ? 3'd7 : 3'd0) : rand_dv();
      tick(r, b, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
